// File: rtl/mem_port_arbiter.sv
// Port-A arbiter for the shared data memory: CPU load/store path vs. an auxiliary requester.
// CPU has priority by default; starvation forcing and an AUX burst lock bound both waits.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_grant_o,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,

    input  logic              aux_req_i,
    input  logic              aux_we_i,
    input  logic              aux_lock_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic [DATA_W-1:0] aux_wdata_i,
    output logic              aux_grant_o,
    output logic              aux_rvalid_o,
    output logic [DATA_W-1:0] aux_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);
    localparam logic          BURST_EN   = (BURST_MAX > 1);

    typedef enum logic {
        ST_OPEN      = 1'b0,
        ST_AUX_BURST = 1'b1
    } state_t;

    state_t          fsm_q, fsm_d;
    logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            rd_cpu_q, rd_cpu_d;
    logic            rd_aux_q, rd_aux_d;

    logic            cpu_win;
    logic            aux_win;
    logic [BW-1:0]   burst_inc;

    // Burst lock and starvation override CPU priority; reset suppresses every grant.
    always_comb begin
        cpu_win = 1'b0;
        aux_win = 1'b0;
        if (!reset_i) begin
            if (aux_req_i && (fsm_q == ST_AUX_BURST || starve_cnt_q == STARVE_LIM)) begin
                aux_win = 1'b1;
            end else if (cpu_req_i) begin
                cpu_win = 1'b1;
            end else if (aux_req_i) begin
                aux_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_o    = cpu_win | aux_win;
        mem_we_o    = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        if (aux_win) begin
            mem_we_o    = aux_we_i;
            mem_addr_o  = aux_addr_i;
            mem_wdata_o = aux_wdata_i;
        end else if (cpu_win) begin
            mem_we_o    = cpu_we_i;
        end
    end

    assign cpu_grant_o  = cpu_win;
    assign aux_grant_o  = aux_win;
    assign cpu_stall_o  = cpu_req_i & ~cpu_win & ~reset_i;
    assign cpu_rvalid_o = rd_cpu_q;
    assign aux_rvalid_o = rd_aux_q;
    assign cpu_rdata_o  = mem_rdata_i;
    assign aux_rdata_o  = mem_rdata_i;

    assign burst_inc = burst_cnt_q + BW'(1);

    always_comb begin
        starve_cnt_d = '0;
        if (aux_req_i && !aux_win) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + SW'(1);
        end

        rd_cpu_d = cpu_win & ~cpu_we_i;
        rd_aux_d = aux_win & ~aux_we_i;

        fsm_d       = fsm_q;
        burst_cnt_d = burst_cnt_q;
        case (fsm_q)
            ST_OPEN: begin
                if (aux_win && aux_lock_i && BURST_EN) begin
                    fsm_d       = ST_AUX_BURST;
                    burst_cnt_d = BW'(1);
                end
            end
            ST_AUX_BURST: begin
                // The beat that reaches BURST_MAX is still granted, then the port reopens.
                if (!aux_lock_i || !aux_req_i || (aux_win && burst_inc == BURST_LIM)) begin
                    fsm_d       = ST_OPEN;
                    burst_cnt_d = '0;
                end else if (aux_win) begin
                    burst_cnt_d = burst_inc;
                end
            end
            default: begin
                fsm_d       = ST_OPEN;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q        <= ST_OPEN;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            rd_cpu_q     <= 1'b0;
            rd_aux_q     <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_cpu_q     <= rd_cpu_d;
            rd_aux_q     <= rd_aux_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and
// constrained-random traffic checked against a history-based reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;
    localparam int BMAX = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, aux_req, aux_we, aux_lock;
    logic [AW-1:0] cpu_addr, aux_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata, mem_wdata, mem_rdata;
    logic          cpu_grant, cpu_stall, cpu_rvalid, aux_grant, aux_rvalid, mem_en, mem_we;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_grant_o  (cpu_grant),
        .cpu_stall_o  (cpu_stall),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_rdata_o  (cpu_rdata),
        .aux_req_i    (aux_req),
        .aux_we_i     (aux_we),
        .aux_lock_i   (aux_lock),
        .aux_addr_i   (aux_addr),
        .aux_wdata_i  (aux_wdata),
        .aux_grant_o  (aux_grant),
        .aux_rvalid_o (aux_rvalid),
        .aux_rdata_o  (aux_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Memory macro stand-in: synchronous write, registered read.
    logic [DW-1:0] mem [256];
    logic          init_mem;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return DW'((i * 40503) ^ 23130);
    endfunction

    always @(posedge clock) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic          rst;
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          areq, awe, alock;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] awd;
        logic          e_cg, e_ag, e_stall;
    } vec_t;

    typedef struct {
        logic          cg, ag, stall, crv, arv;
        logic [DW-1:0] crd, ard;
    } obs_t;

    function automatic vec_t mk(input logic rst, input logic creq, input logic cwe,
                                input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                                input logic areq, input logic awe, input logic alock,
                                input logic [AW-1:0] aaddr, input logic [DW-1:0] awd,
                                input logic e_cg, input logic e_ag, input logic e_stall);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.areq = areq; v.awe = awe; v.alock = alock; v.aaddr = aaddr; v.awd = awd;
        v.e_cg = e_cg; v.e_ag = e_ag; v.e_stall = e_stall;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%04h expected 0x%04h", name, cyc, act, exp);
        end
    endtask

    // Reference model: arbitration derived from request/grant history rather than state.
    // deny_run  = consecutive previous cycles in which AUX asked and was refused.
    // lock_run  = consecutive previous cycles in which AUX was granted with lock held;
    //             a locked burst is in progress whenever that run is not a multiple of BMAX.
    int            deny_run = 0;
    int            lock_run = 0;
    logic          exp_rd_cpu = 1'b0, exp_rd_aux = 1'b0;
    logic [DW-1:0] exp_cpu_data = '0, exp_aux_data = '0;
    logic [DW-1:0] ref_mem [256];

    task automatic run_cycle(input vec_t v, output obs_t o);
        logic in_burst, forced, e_cg, e_ag, e_st;
        reset = v.rst;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        aux_req = v.areq; aux_we = v.awe; aux_lock = v.alock; aux_addr = v.aaddr; aux_wdata = v.awd;
        @(negedge clock);

        in_burst = (BMAX > 1) && ((lock_run % BMAX) != 0);
        forced   = (deny_run >= SMAX);
        e_ag = !v.rst && v.areq && (in_burst || forced || !v.creq);
        e_cg = !v.rst && v.creq && !e_ag;
        e_st = !v.rst && v.creq && !e_cg;

        chk1("cpu_grant", cpu_grant, e_cg);
        chk1("aux_grant", aux_grant, e_ag);
        chk1("cpu_stall", cpu_stall, e_st);
        chk1("mem_en", mem_en, e_cg || e_ag);
        chk1("mem_we", mem_we, e_cg ? v.cwe : (e_ag ? v.awe : 1'b0));
        if (e_cg) begin
            chk16("mem_addr_cpu", mem_addr, v.caddr);
            if (v.cwe) chk16("mem_wdata_cpu", mem_wdata, v.cwd);
        end
        if (e_ag) begin
            chk16("mem_addr_aux", mem_addr, v.aaddr);
            if (v.awe) chk16("mem_wdata_aux", mem_wdata, v.awd);
        end
        chk1("cpu_rvalid", cpu_rvalid, exp_rd_cpu);
        chk1("aux_rvalid", aux_rvalid, exp_rd_aux);
        if (exp_rd_cpu) chk16("cpu_rdata", cpu_rdata, exp_cpu_data);
        if (exp_rd_aux) chk16("aux_rdata", aux_rdata, exp_aux_data);

        o.cg = cpu_grant; o.ag = aux_grant; o.stall = cpu_stall;
        o.crv = cpu_rvalid; o.arv = aux_rvalid; o.crd = cpu_rdata; o.ard = aux_rdata;

        if (v.rst) begin
            deny_run   = 0;
            lock_run   = 0;
            exp_rd_cpu = 1'b0;
            exp_rd_aux = 1'b0;
        end else begin
            deny_run   = (v.areq && !e_ag) ? deny_run + 1 : 0;
            lock_run   = (e_ag && v.alock) ? lock_run + 1 : 0;
            exp_rd_cpu = e_cg && !v.cwe;
            exp_rd_aux = e_ag && !v.awe;
            if (exp_rd_cpu) exp_cpu_data = ref_mem[v.caddr[7:0]];
            if (exp_rd_aux) exp_aux_data = ref_mem[v.aaddr[7:0]];
            if (e_cg && v.cwe) ref_mem[v.caddr[7:0]] = v.cwd;
            if (e_ag && v.awe) ref_mem[v.aaddr[7:0]] = v.awd;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v, idle, prev;
        obs_t o, po;
        logic [AW-1:0] ca, aa;

        ca = 16'h0001;
        aa = 16'h0002;
        idle = mk(0, 0, 0, ca, 16'h0, 0, 0, 0, aa, 16'h0, 0, 0, 0);

        init_mem = 1'b1;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_lock = 0; aux_addr = '0; aux_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(posedge clock);
        #1;
        init_mem = 1'b0;

        // Reset hold with both requesting, then the starvation pattern straight out of reset.
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 0, ca, 0, 1, 0, 0, aa, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            tbl.push_back(mk(0, 1, 0, ca, 0, 1, 0, 0, aa, 0,
                             (k % 5) != 0, (k % 5) == 0, (k % 5) == 0));
        end
        tbl.push_back(idle);
        // Locked AUX burst; CPU raises its request on beat 2 and wins on beat 5.
        tbl.push_back(mk(0, 0, 0, ca, 0, 1, 0, 1, aa, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 0, ca, 0, 1, 0, 1, aa, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, ca, 0, 1, 0, 1, aa, 0, 1, 0, 0));
        tbl.push_back(idle);

        foreach (tbl[i]) begin
            run_cycle(tbl[i], o);
            chk1($sformatf("tbl%0d_cpu_grant", i), o.cg, tbl[i].e_cg);
            chk1($sformatf("tbl%0d_aux_grant", i), o.ag, tbl[i].e_ag);
            chk1($sformatf("tbl%0d_cpu_stall", i), o.stall, tbl[i].e_stall);
        end

        // Uncontested CPU read of a preloaded word.
        run_cycle(mk(0, 1, 0, 16'h0010, 0, 0, 0, 0, aa, 0, 0, 0, 0), o);
        chk1("cpu_read_grant", o.cg, 1'b1);
        run_cycle(idle, o);
        chk1("cpu_read_rvalid", o.crv, 1'b1);
        chk16("cpu_read_rdata", o.crd, 16'hBEEF);
        chk1("cpu_read_aux_rvalid", o.arv, 1'b0);

        // AUX write followed immediately by a CPU read of the same word.
        run_cycle(mk(0, 0, 0, ca, 0, 1, 1, 0, 16'h0020, 16'h1234, 0, 0, 0), o);
        chk1("wr_aux_grant", o.ag, 1'b1);
        run_cycle(mk(0, 1, 0, 16'h0020, 0, 0, 0, 0, aa, 0, 0, 0, 0), o);
        chk1("wr_rd_cpu_grant", o.cg, 1'b1);
        run_cycle(idle, o);
        chk1("wr_rd_rvalid", o.crv, 1'b1);
        chk16("wr_rd_rdata", o.crd, 16'h1234);

        // Reset lands on beat 2 of a locked AUX read burst.
        run_cycle(mk(0, 0, 0, ca, 0, 1, 0, 1, 16'h0030, 0, 0, 0, 0), o);
        chk1("rstb_beat1_grant", o.ag, 1'b1);
        run_cycle(mk(1, 0, 0, ca, 0, 1, 0, 1, 16'h0031, 0, 0, 0, 0), o);
        chk1("rstb_beat2_grant", o.ag, 1'b0);
        chk1("rstb_beat2_rvalid", o.arv, 1'b1);
        run_cycle(mk(0, 1, 0, ca, 0, 1, 0, 1, 16'h0031, 0, 0, 0, 0), o);
        chk1("rstb_after_rvalid", o.arv, 1'b0);
        chk1("rstb_after_cpu_wins", o.cg, 1'b1);
        run_cycle(idle, o);

        // Random traffic: a refused request stays stable until granted.
        prev = idle;
        po   = o;
        po.cg = 1'b1;
        po.ag = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            v = idle;
            v.rst = ($urandom_range(0, 99) == 0);
            if (prev.creq && !po.cg) begin
                v.creq = prev.creq; v.cwe = prev.cwe; v.caddr = prev.caddr; v.cwd = prev.cwd;
            end else begin
                v.creq  = ($urandom_range(0, 3) != 0);
                v.cwe   = $urandom_range(0, 1) == 1;
                v.caddr = AW'($urandom_range(0, 31));
                v.cwd   = DW'($urandom);
            end
            if (prev.areq && !po.ag) begin
                v.areq = prev.areq; v.awe = prev.awe; v.alock = prev.alock;
                v.aaddr = prev.aaddr; v.awd = prev.awd;
            end else begin
                v.areq  = ($urandom_range(0, 2) != 0);
                v.awe   = $urandom_range(0, 1) == 1;
                v.alock = ($urandom_range(0, 3) != 0);
                v.aaddr = AW'($urandom_range(0, 31));
                v.awd   = DW'($urandom);
            end
            run_cycle(v, o);
            prev = v;
            po   = o;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
